// File: rtl/fact_unit.sv
// fact_unit: memory-mapped iterative factorial accelerator with a one-cycle done pulse
// Optional feature macro: FACT_IRQ_MASK_EN adds an IE register at offset 0x10 that masks done.
module fact_unit #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter int          WIDTH     = 32,
    parameter int          N_W       = 4,
    parameter int          MAX_N     = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_addr,
    input  logic        write_enable,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        done,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [N_W-1:0] MAX_NV = N_W'(MAX_N);
    localparam logic [N_W-1:0] ONE    = N_W'(1);

    state_t           state;
    logic [N_W-1:0]   n;
    logic [N_W-1:0]   cnt;
    logic [WIDTH-1:0] result;
    logic             done_flag;
    logic             err;
    logic             ie_rd;

    logic       sel;
    logic [2:0] off;
    logic       wr;
    logic       go;
    logic       unused_bits;

    assign sel         = input_addr[31:12] == BASE_ADDR[31:12];
    assign off         = input_addr[4:2];
    assign wr          = sel & write_enable;
    assign go          = wr & (off == 3'd1) & write_data[0];
    assign busy        = state == CALC;
    assign unused_bits = ^{write_data[31:N_W], input_addr[11:5], input_addr[1:0]};

`ifdef FACT_IRQ_MASK_EN
    logic ie;

    // Interrupt enable register; done_flag and STATUS are not affected by it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ie <= 1'b1;
        else if (wr && off == 3'd4)
            ie <= write_data[0];
    end

    assign ie_rd = ie;
    assign done  = (state == DONE) & ie;
`else
    assign ie_rd = 1'b0;
    assign done  = state == DONE;
`endif

    // Control FSM and datapath: operand snapshot in cnt, result multiplied down to 1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            n         <= '0;
            cnt       <= '0;
            result    <= '0;
            done_flag <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr && off == 3'd0)
                        n <= write_data[N_W-1:0];
                    if (go) begin
                        done_flag <= 1'b0;
                        if (n > MAX_NV) begin
                            err    <= 1'b1;
                            result <= '0;
                            state  <= DONE;
                        end else begin
                            err    <= 1'b0;
                            result <= WIDTH'(1);
                            cnt    <= n;
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (cnt <= ONE) begin
                        state <= DONE;
                    end else begin
                        result <= result * WIDTH'(cnt);
                        cnt    <= cnt - ONE;
                    end
                end
                DONE: begin
                    done_flag <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Zero-wait-state read mux; unselected or unmapped addresses read 0
    always_comb begin
        read_data = '0;
        if (sel)
            read_data = off == 3'd0 ? 32'(n) :
                        off == 3'd2 ? {29'd0, busy, err, done_flag} :
                        off == 3'd3 ? 32'(result) :
                        off == 3'd4 ? {31'd0, ie_rd} : '0;
    end
endmodule

// File: tb/tb_fact_unit.sv
// tb_fact_unit: directed and randomized checks of fact_unit against a factorial reference model
module tb_fact_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0, wd = '0, a3 = '0, wd3 = '0;
    logic        we = 1'b0, we3 = 1'b0;
    logic [31:0] rd, rd3;
    logic        done, done3, busy, busy3;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fact_unit #(.BASE_ADDR(32'h0000_3000)) u0 (
        .clk(clk), .rst(rst), .input_addr(addr), .write_enable(we),
        .write_data(wd), .read_data(rd), .done(done), .busy(busy)
    );

    fact_unit #(.BASE_ADDR(32'h0000_6000)) u3 (
        .clk(clk), .rst(rst), .input_addr(a3), .write_enable(we3),
        .write_data(wd3), .read_data(rd3), .done(done3), .busy(busy3)
    );

    function automatic logic [31:0] fact_ref(int n);
        logic [31:0] f = 32'd1;
        for (int i = 2; i <= n; i++) f = 32'(f * 32'(i));
        return f;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(logic [31:0] a, logic [31:0] d);
        @(negedge clk);
        addr = a; wd = d; we = 1'b1;
        @(posedge clk);
        #1 we = 1'b0;
    endtask

    task automatic wr3(logic [31:0] a, logic [31:0] d);
        @(negedge clk);
        a3 = a; wd3 = d; we3 = 1'b1;
        @(posedge clk);
        #1 we3 = 1'b0;
    endtask

    task automatic bus_rd(logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1 d = rd;
    endtask

    // Start a computation and measure latency, busy length and pulse count
    task automatic run(int n);
        int          pulses = 0, first = -1, busy_cyc = 0;
        int          exp_lat;
        logic [31:0] v;
        exp_lat = n > 12 ? 0 : (n <= 1 ? 1 : n);
        bus_wr(32'h3000, 32'(n));
        bus_wr(32'h3004, 32'd1);
        for (int s = 0; s < 40; s++) begin
            if (s > 0) begin
                @(posedge clk);
                #1;
            end
            if (done) begin
                pulses++;
                if (first < 0) first = s;
            end
            if (busy) busy_cyc++;
        end
        check($sformatf("pulses n=%0d", n), 32'(pulses), 32'd1);
        check($sformatf("latency n=%0d", n), 32'(first), 32'(exp_lat));
        check($sformatf("busy_cycles n=%0d", n), 32'(busy_cyc), n > 12 ? 32'd0 : 32'(exp_lat));
        bus_rd(32'h300C, v);
        check($sformatf("result n=%0d", n), v, n > 12 ? 32'd0 : fact_ref(n));
        bus_rd(32'h3008, v);
        check($sformatf("status n=%0d", n), v, n > 12 ? 32'd3 : 32'd1);
    endtask

    initial begin
        logic [31:0] v;
        int          p0, p3, f0, f3, mis;
        #2;
        check("reset_done", 32'(done), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        bus_rd(32'h3008, v); check("reset_status", v, 32'd0);
        bus_rd(32'h300C, v); check("reset_result", v, 32'd0);
        bus_rd(32'h3000, v); check("reset_n", v, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run(5);
        bus_rd(32'h3004, v); check("go_reads_zero", v, 32'd0);
        bus_rd(32'h6000, v); check("unselected_read", v, 32'd0);
        a3 = 32'h600C; #1 check("other_inst_untouched", rd3, 32'd0);
        run(0);
        run(1);
        run(12);
        run(13);

        bus_wr(32'h3014, 32'hFFFF_FFFF);
        bus_rd(32'h3014, v); check("unmapped_read", v, 32'd0);
        bus_wr(32'h7000, 32'd9);
        bus_rd(32'h3000, v); check("sel0_write_ignored", v, 32'd13);

        @(negedge clk);
        addr = 32'h3000; wd = 32'd7; we = 1'b1;
        #1 check("read_old_before_edge", rd, 32'd13);
        @(posedge clk);
        #1 we = 1'b0;
        check("read_new_after_edge", rd, 32'd7);

        bus_wr(32'h3000, 32'd10);
        bus_wr(32'h3004, 32'd1);
        bus_wr(32'h3000, 32'd3);
        bus_wr(32'h3004, 32'd1);
        p0 = 0;
        for (int s = 0; s < 40; s++) begin
            @(posedge clk);
            #1 if (done) p0++;
        end
        check("busy_writes_pulses", 32'(p0), 32'd1);
        bus_rd(32'h300C, v); check("busy_writes_result", v, 32'd3628800);
        bus_rd(32'h3000, v); check("busy_writes_n", v, 32'd10);

        bus_wr(32'h3000, 32'd12);
        bus_wr(32'h3004, 32'd1);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        bus_rd(32'h300C, v); check("abort_result", v, 32'd0);
        bus_rd(32'h3008, v); check("abort_status", v, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        p0 = 0;
        for (int s = 0; s < 20; s++) begin
            @(posedge clk);
            #1 if (done) p0++;
        end
        check("abort_no_pulse", 32'(p0), 32'd0);
        run(4);

        bus_wr(32'h3000, 32'd3);
        wr3(32'h6000, 32'd3);
        @(negedge clk);
        addr = 32'h3004; wd = 32'd1; we = 1'b1;
        a3 = 32'h6004; wd3 = 32'd1; we3 = 1'b1;
        @(posedge clk);
        #1 we = 1'b0; we3 = 1'b0;
        check("dual_busy3", 32'(busy3), 32'd1);
        p0 = 0; p3 = 0; f0 = -1; f3 = -1; mis = 0;
        for (int s = 0; s < 20; s++) begin
            if (s > 0) begin
                @(posedge clk);
                #1;
            end
            if (done) begin p0++; if (f0 < 0) f0 = s; end
            if (done3) begin p3++; if (f3 < 0) f3 = s; end
            if (done !== done3) mis++;
        end
        check("dual_pulses0", 32'(p0), 32'd1);
        check("dual_pulses3", 32'(p3), 32'd1);
        check("dual_latency", 32'(f3), 32'd3);
        check("dual_same_cycle", 32'(mis), 32'd0);
        a3 = 32'h600C; #1 check("dual_result3", rd3, 32'd6);

`ifdef FACT_IRQ_MASK_EN
        bus_rd(32'h3010, v); check("ie_reset", v, 32'd1);
        bus_wr(32'h3010, 32'd0);
        bus_wr(32'h3000, 32'd2);
        bus_wr(32'h3004, 32'd1);
        p0 = 0;
        for (int s = 0; s < 20; s++) begin
            @(posedge clk);
            #1 if (done) p0++;
        end
        check("masked_no_pulse", 32'(p0), 32'd0);
        bus_rd(32'h3008, v); check("masked_status", v, 32'd1);
        bus_wr(32'h3010, 32'd1);
`else
        bus_wr(32'h3010, 32'd1);
        bus_rd(32'h3010, v); check("ie_unmapped", v, 32'd0);
`endif

        for (int i = 0; i < 8; i++) run(int'($urandom_range(0, 15)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fact_unit.md
Name: fact_unit

Overview:
- Memory-mapped iterative factorial accelerator. One instance per factorial slot: four instances at 0x3000, 0x4000, 0x5000 and 0x6000.
- Sits directly upstream of the interrupt controller. Its `done` output drives one bit of the controller's `done[3:0]` vector.
- The CPU writes N and then GO. The unit computes N! by repeated multiplication and pulses `done` for one cycle when the result is ready.

Parameters:
- BASE_ADDR, 32'h00003000, 4 KB window base; only bits [31:12] are compared.
- WIDTH, 32, width of the result register and datapath.
- N_W, 4, width of the N operand register.
- MAX_N, 12, largest N whose factorial fits in WIDTH bits. N > MAX_N is an error.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- input_addr  in  32  CPU bus address.
- write_enable  in  1  bus write strobe, sampled on the clock edge.
- write_data  in  32  bus write data.
- read_data  out  32  combinational read data; 0 when the address is not selected.
- done  out  1  one-cycle completion pulse to the interrupt controller.
- busy  out  1  high while the unit is in CALC.

Behaviour:
- Select: `sel = (input_addr[31:12] == BASE_ADDR[31:12])`. The register offset is `input_addr[4:2]`.
- Register map:
  - 0x0 N (R/W, bits [N_W-1:0]).
  - 0x4 GO (write 1 to bit0 to start; reads 0).
  - 0x8 STATUS (RO): bit0 done_flag, bit1 err, bit2 busy.
  - 0xC RESULT (RO, WIDTH bits).
  - Unmapped offsets read 0 and ignore writes.
- Reads are combinational, with no wait state.
- Reset (rst=0, asynchronous): state=IDLE; N, RESULT, cnt, done_flag and err cleared; done=0; busy=0; read_data reflects the cleared registers.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - A GO write (sel & write_enable & offset 0x4 & write_data[0]) at edge k clears done_flag and err.
  - If N > MAX_N: err<=1, RESULT<=0, state<=DONE at edge k.
  - Otherwise: RESULT<=1, cnt<=N, state<=CALC.
- CALC, evaluated each edge:
  - If cnt <= 1: state<=DONE.
  - Otherwise: RESULT <= RESULT*cnt, truncated to WIDTH bits; cnt <= cnt-1.
- DONE:
  - `done` is asserted combinationally for exactly this one cycle.
  - At the next edge: done_flag<=1, state<=IDLE.
- Latency: DONE is entered at edge k+N for N >= 2, and at edge k+1 for N in {0,1}.
  - N=0 gives RESULT 1.
  - RESULT holds its final value until the next GO.
- Writes while busy:
  - A GO write during CALC or DONE is ignored.
  - An N write during CALC or DONE is ignored; the operand snapshot lives in cnt.
- `busy` = (state==CALC).
- Reset mid-computation aborts immediately; no `done` pulse is generated.
- Writes with sel=0 are ignored. Simultaneous write and read to the same register: the read returns the old value until the edge.

Optional Feature:
- Macro: FACT_IRQ_MASK_EN.
- Enabled:
  - Adds IE register at offset 0x10 (R/W bit0), reset value 1.
  - `done` = (state==DONE) & IE.
  - done_flag and STATUS update regardless of IE.
- Disabled:
  - Offset 0x10 is unmapped and reads 0.
  - `done` is unmasked.

Test Plan:
- Reset, then read 0x3008 and 0x300C -> both 0; done=0; busy=0.
- Write N=5 to 0x3000, then GO -> busy high for 5 cycles; done pulses high for exactly 1 cycle; RESULT 0x78; STATUS=0x1.
- N=0, then GO -> done one cycle later; RESULT 1. N=12 -> RESULT 0x1C8CFC00. N=13 -> err=1, RESULT 0, done pulses once, STATUS=0x3.
- During N=10 computation, write N=3 and GO again -> both ignored; RESULT 0x00375F00 (3628800); exactly one done pulse.
- Assert rst mid-CALC (N=12) -> outputs cleared asynchronously; no done pulse; a subsequent GO with N=4 gives 0x18.
- Four instances feeding the interrupt controller: start 0x6000 (N=3) and 0x3000 (N=3) together -> both done pulses land on the same cycle. With FACT_IRQ_MASK_EN, IE=0 -> no pulse, but done_flag=1.
